// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit: request handshake, writeback handshake, flush, busy.
interface mdu_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [4:0]  in_rd_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd_addr;
  logic [63:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd_addr, flush, out_ready,
    input  in_ready, out_valid, out_rd_addr, out_data, busy
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd_addr, flush, out_ready,
    output in_ready, out_valid, out_rd_addr, out_data, busy
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit. Radix-2 shift-add multiply and
// restoring shift-subtract divide on operand magnitudes, with sign fix-up
// after the last iteration. Divide-by-zero, signed overflow and illegal
// W codes bypass the iteration and complete one cycle after acceptance.
module mdu_iter (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  count;
  logic        w_op;
  logic        is_div;
  logic        is_rem;
  logic        is_mulh;
  logic        res_neg;
  logic [63:0] m_reg;
  logic [64:0] acc_hi;
  logic [63:0] acc_lo;

  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic [63:0] out_data_q;
  logic [4:0]  out_rd_q;

  logic [2:0]  f3;
  logic        wf;
  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] rs1_w;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] a_mag;
  logic [63:0] b_mag;
  logic        w_illegal;
  logic        div_zero;
  logic        div_ovf;
  logic        fast_path;
  logic [63:0] fast_data;
  logic [63:0] init_lo;

  logic [64:0] mul_sum;
  logic [64:0] div_shift;
  logic [65:0] div_diff;
  logic [64:0] nxt_hi;
  logic [63:0] nxt_lo;

  logic [127:0] prod;
  logic [127:0] prod_s;
  logic [63:0]  pick;
  logic [63:0]  fixed;
  logic [63:0]  final_data;
  logic         last_iter;

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_rd_addr = out_rd_q;
  assign bus.busy        = busy_q;

  // Decode the incoming request: operand extension, magnitudes and fast-path results
  always_comb begin
    f3    = bus.in_op[2:0];
    wf    = bus.in_op[3];
    rs1_w = {{32{bus.in_rs1[31]}}, bus.in_rs1[31:0]};
    if (f3[2]) begin
      a_signed = ~f3[0];
      b_signed = ~f3[0];
    end else begin
      a_signed = (f3 != 3'b011);
      b_signed = ~f3[1];
    end
    if (wf) begin
      a_ext = a_signed ? rs1_w : {32'd0, bus.in_rs1[31:0]};
      b_ext = b_signed ? {{32{bus.in_rs2[31]}}, bus.in_rs2[31:0]} : {32'd0, bus.in_rs2[31:0]};
    end else begin
      a_ext = bus.in_rs1;
      b_ext = bus.in_rs2;
    end
    a_neg = a_signed & a_ext[63];
    b_neg = b_signed & b_ext[63];
    a_mag = a_neg ? (64'd0 - a_ext) : a_ext;
    b_mag = b_neg ? (64'd0 - b_ext) : b_ext;

    w_illegal = wf & ~f3[2] & (f3[1:0] != 2'b00);
    div_zero  = f3[2] & (b_ext == 64'd0);
    div_ovf   = f3[2] & ~f3[0] & (b_ext == 64'hFFFF_FFFF_FFFF_FFFF) &
                (wf ? (bus.in_rs1[31:0] == 32'h8000_0000)
                    : (bus.in_rs1 == 64'h8000_0000_0000_0000));
    fast_path = w_illegal | div_zero | div_ovf;

    fast_data = 64'd0;
    if (!w_illegal) begin
      if (div_zero) begin
        fast_data = f3[1] ? (wf ? rs1_w : bus.in_rs1) : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (div_ovf) begin
        fast_data = f3[1] ? 64'd0 : (wf ? rs1_w : bus.in_rs1);
      end
    end

    if (f3[2]) begin
      init_lo = wf ? {a_mag[31:0], 32'd0} : a_mag;
    end else begin
      init_lo = b_mag;
    end
  end

  // One iteration of shift-add multiply or restoring divide on the accumulators
  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, m_reg} : 65'd0);
    div_shift = {acc_hi[63:0], acc_lo[63]};
    div_diff  = {1'b0, div_shift} - {2'b00, m_reg};
    if (!is_div) begin
      nxt_hi = {1'b0, mul_sum[64:1]};
      nxt_lo = {mul_sum[0], acc_lo[63:1]};
    end else if (!div_diff[65]) begin
      nxt_hi = div_diff[64:0];
      nxt_lo = {acc_lo[62:0], 1'b1};
    end else begin
      nxt_hi = div_shift;
      nxt_lo = {acc_lo[62:0], 1'b0};
    end
  end

  // Select and sign-fix the result from the accumulators after the final iteration
  always_comb begin
    prod   = {nxt_hi[63:0], nxt_lo};
    prod_s = res_neg ? (128'd0 - prod) : prod;
    pick   = 64'd0;
    fixed  = 64'd0;
    if (is_div) begin
      pick  = is_rem ? nxt_hi[63:0] : nxt_lo;
      fixed = res_neg ? (64'd0 - pick) : pick;
    end else if (w_op) begin
      pick  = prod[95:32];
      fixed = res_neg ? (64'd0 - pick) : pick;
    end else begin
      fixed = is_mulh ? prod_s[127:64] : prod_s[63:0];
    end
    final_data = w_op ? {{32{fixed[31]}}, fixed[31:0]} : fixed;
    last_iter  = (count == (w_op ? 6'd31 : 6'd63));
  end

  // Control FSM: accept, iterate, present result; flush aborts from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 6'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= 64'd0;
      out_rd_q    <= 5'd0;
      w_op        <= 1'b0;
      is_div      <= 1'b0;
      is_rem      <= 1'b0;
      is_mulh     <= 1'b0;
      res_neg     <= 1'b0;
      m_reg       <= 64'd0;
      acc_hi      <= 65'd0;
      acc_lo      <= 64'd0;
    end else if (bus.flush) begin
      state       <= IDLE;
      count       <= 6'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            w_op       <= wf;
            is_div     <= f3[2];
            is_rem     <= f3[1];
            is_mulh    <= (f3 != 3'b000);
            res_neg    <= (f3[2] & f3[1]) ? a_neg : (a_neg ^ b_neg);
            m_reg      <= f3[2] ? b_mag : a_mag;
            acc_hi     <= 65'd0;
            acc_lo     <= init_lo;
            count      <= 6'd0;
            out_rd_q   <= bus.in_rd_addr;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (fast_path) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= fast_data;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          count  <= count + 6'd1;
          if (last_iter) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= final_data;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: directed cases, flush/reset scenarios and
// randomized operations compared against an arithmetic reference model.
module tb_mdu_iter;

  logic clk = 1'b0;
  logic rst;

  mdu_iter_if bus();

  mdu_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        tx_active = 1'b0;
  logic [63:0] exp_data = 64'd0;
  logic [4:0]  exp_rd = 5'd0;
  int          exp_lat = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // RV64M result computed directly from the instruction semantics
  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, pp;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         ua32, ub32, r32;
    logic [63:0]         r;
    sa = a; sb = b;
    ua32 = a[31:0]; ub32 = b[31:0];
    sa32 = ua32; sb32 = ub32;
    r = 64'd0; r32 = 32'd0;
    if (!op[3]) begin
      case (op[2:0])
        3'd0: r = a * b;
        3'd1: begin pa = sa; pb = sb; pp = pa * pb; r = pp[127:64]; end
        3'd2: begin pa = sa; pb = {64'd0, b}; pp = pa * pb; r = pp[127:64]; end
        3'd3: begin pp = {64'd0, a} * {64'd0, b}; r = pp[127:64]; end
        3'd4: begin
          if (b == 64'd0) r = ONES;
          else if (a == MIN64 && b == ONES) r = a;
          else r = sa / sb;
        end
        3'd5: r = (b == 64'd0) ? ONES : a / b;
        3'd6: begin
          if (b == 64'd0) r = a;
          else if (a == MIN64 && b == ONES) r = 64'd0;
          else r = sa % sb;
        end
        default: r = (b == 64'd0) ? a : a % b;
      endcase
    end else begin
      case (op[2:0])
        3'd0: r32 = ua32 * ub32;
        3'd4: begin
          if (ub32 == 32'd0) r32 = 32'hFFFF_FFFF;
          else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
          else r32 = sa32 / sb32;
        end
        3'd5: r32 = (ub32 == 32'd0) ? 32'hFFFF_FFFF : ua32 / ub32;
        3'd6: begin
          if (ub32 == 32'd0) r32 = ua32;
          else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = 32'd0;
          else r32 = sa32 % sb32;
        end
        3'd7: r32 = (ub32 == 32'd0) ? ua32 : ua32 % ub32;
        default: r32 = 32'd0;
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  // Cycles from acceptance to out_valid
  function automatic int model_latency(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[3] && !op[2] && op[1:0] != 2'b00) return 1;
    if (op[2]) begin
      if (op[3]) begin
        if (b[31:0] == 32'd0) return 1;
        if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      end else begin
        if (b == 64'd0) return 1;
        if (!op[0] && a == MIN64 && b == ONES) return 1;
      end
    end
    return op[3] ? 33 : 65;
  endfunction

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return ONES;
      2: return MIN64;
      3: return {32'($urandom), 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic checkReset(input string name);
    checkOutput({name, "_in_ready"},  64'(bus.in_ready), 64'd1);
    checkOutput({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({name, "_busy"},      64'(bus.busy), 64'd0);
    checkOutput({name, "_out_data"},  bus.out_data, 64'd0);
    checkOutput({name, "_out_rd"},    64'(bus.out_rd_addr), 64'd0);
  endtask

  // Present one request, wait for acceptance, then wait for out_valid and check latency
  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input string name);
    int cyc;
    bit seen;
    @(negedge clk);
    checkOutput({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs1     = a;
    bus.in_rs2     = b;
    bus.in_rd_addr = rd;
    exp_data = model_result(op, a, b);
    exp_rd   = rd;
    exp_lat  = model_latency(op, a, b);
    @(posedge clk);
    tx_active = 1'b1;
    #1;
    bus.in_valid   = 1'b0;
    bus.in_op      = 4'($urandom);
    bus.in_rs1     = {32'($urandom), 32'($urandom)};
    bus.in_rs2     = {32'($urandom), 32'($urandom)};
    bus.in_rd_addr = 5'($urandom);
    seen = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({name, "_latency"}, seen ? 64'(cyc) : 64'd0, 64'(exp_lat));
  endtask

  // Hold off writeback for a while, then complete the handshake
  task automatic finishTx(input int hold, input string name);
    for (int i = 0; i < hold; i++) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, "_drain_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({name, "_drain_ready"}, 64'(bus.in_ready), 64'd1);
    tx_active = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Every cycle a result is presented it must match the model and hold the unit busy
  always @(negedge clk) begin
    if (!rst && tx_active && bus.out_valid) begin
      checkOutput("out_data", bus.out_data, exp_data);
      checkOutput("out_rd_addr", 64'(bus.out_rd_addr), 64'(exp_rd));
      checkOutput("in_ready_in_done", 64'(bus.in_ready), 64'd0);
      checkOutput("busy_in_done", 64'(bus.busy), 64'd1);
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0]  rop;
    logic [63:0] ra, rb;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op = 4'd0;
    bus.in_rs1 = 64'd0;
    bus.in_rs2 = 64'd0;
    bus.in_rd_addr = 5'd0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    checkOutput("pin_mul",    model_result(4'h0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB), 64'hFFFF_FFFF_FFFF_FFF1);
    checkOutput("pin_mulhu",  model_result(4'h3, ONES, ONES), 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("pin_mulh",   model_result(4'h1, ONES, ONES), 64'd0);
    checkOutput("pin_div_ov", model_result(4'h4, MIN64, ONES), MIN64);
    checkOutput("pin_rem_ov", model_result(4'h6, MIN64, ONES), 64'd0);
    checkOutput("pin_divu0",  model_result(4'h5, 64'd100, 64'd0), ONES);
    checkOutput("pin_remu0",  model_result(4'h7, 64'd100, 64'd0), 64'd100);
    checkOutput("pin_divw",   model_result(4'hC, 64'h0000_0000_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("pin_remw",   model_result(4'hE, 64'h0000_0000_FFFF_FFF9, 64'd2), ONES);
    checkOutput("pin_divuw",  model_result(4'hD, 64'h0000_0000_FFFF_FFFE, 64'd1), 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("pin_lat64",  64'(model_latency(4'h0, 64'd3, 64'd5)), 64'd65);
    checkOutput("pin_latw",   64'(model_latency(4'hC, 64'd7, 64'd2)), 64'd33);
    checkOutput("pin_latfp",  64'(model_latency(4'h5, 64'd100, 64'd0)), 64'd1);

    bus.out_ready = 1'b1;
    applyStimulus(4'h0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd7, "mul");
    finishTx(0, "mul");
    applyStimulus(4'h3, ONES, ONES, 5'd1, "mulhu");
    finishTx(0, "mulhu");
    applyStimulus(4'h1, ONES, ONES, 5'd2, "mulh");
    finishTx(0, "mulh");
    applyStimulus(4'h4, MIN64, ONES, 5'd3, "div_ovf");
    finishTx(0, "div_ovf");
    applyStimulus(4'h6, MIN64, ONES, 5'd4, "rem_ovf");
    finishTx(0, "rem_ovf");
    applyStimulus(4'h5, 64'd100, 64'd0, 5'd5, "divu0");
    finishTx(0, "divu0");
    applyStimulus(4'h7, 64'd100, 64'd0, 5'd6, "remu0");
    finishTx(0, "remu0");
    applyStimulus(4'hC, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd8, "divw");
    finishTx(0, "divw");
    applyStimulus(4'hE, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd9, "remw");
    finishTx(0, "remw");
    applyStimulus(4'hD, 64'h0000_0000_FFFF_FFFE, 64'd1, 5'd10, "divuw");
    finishTx(0, "divuw");
    applyStimulus(4'h9, 64'd5, 64'd6, 5'd11, "w_illegal");
    finishTx(0, "w_illegal");

    applyStimulus(4'h8, 64'hFFFF_FFFF_8765_4321, 64'h0000_0000_1234_5678, 5'd12, "hold");
    finishTx(10, "hold");

    // Flush in the middle of an iterative multiply
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = 4'h0;
    bus.in_rs1 = 64'h0123_4567_89AB_CDEF;
    bus.in_rs2 = 64'd99;
    bus.in_rd_addr = 5'd13;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (21) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("flush_busy",      64'(bus.busy), 64'd0);
    checkOutput("flush_in_ready",  64'(bus.in_ready), 64'd1);
    repeat (70) @(negedge clk);
    checkOutput("flush_no_result", 64'(bus.out_valid), 64'd0);

    applyStimulus(4'h0, 64'd6, 64'd7, 5'd0, "mul_after_flush");
    finishTx(0, "mul_after_flush");

    // Flush coincident with a request in IDLE: nothing accepted
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = 4'h5;
    bus.in_rs1 = 64'd1;
    bus.in_rs2 = 64'd0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    checkOutput("flush_accept_busy",  64'(bus.busy), 64'd0);
    checkOutput("flush_accept_valid", 64'(bus.out_valid), 64'd0);

    // Reset while a result is waiting in DONE
    bus.out_ready = 1'b0;
    applyStimulus(4'h5, 64'd100, 64'd0, 5'd9, "rst_done");
    tx_active = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkReset("rst_in_done");
    rst = 1'b0;

    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = randOperand();
      rb = randOperand();
      applyStimulus(rop, ra, rb, 5'($urandom), "rand");
      finishTx($urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
